// File: rtl/dma_copy.sv
// Single-channel word-granular memory-to-memory copy engine with a RIB slave register port
// and a RIB master port; alternates one read and one write per word until the length is spent.
module dma_copy #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [DATA_W-1:0] s_data_o,
  input  logic              s_we_i,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic [DATA_W-1:0] m_data_i,
  output logic              m_req_o,
  output logic              m_we_o,
  input  logic              m_gnt_i,
  output logic              irq_o
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              ien_q, ien_d, done_q, done_d, irq_q, irq_d;

  logic       busy;
  logic       start;
  logic [1:0] reg_sel;
  logic       unused_addr;

  assign unused_addr = ^{s_addr_i[ADDR_W-1:4], s_addr_i[1:0]};
  assign reg_sel     = s_addr_i[3:2];
  assign busy        = (state_q != StIdle);
  assign start       = s_we_i && (reg_sel == 2'd0) && s_data_i[0] && !busy;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    ien_d     = ien_q;
    done_d    = done_q;
    irq_d     = done_q & ien_q;

    if (s_we_i) begin
      unique case (reg_sel)
        2'd0: begin
          ien_d = s_data_i[3];
          if (s_data_i[2]) done_d = 1'b0;
        end
        2'd1: if (!busy) src_d = {s_data_i[ADDR_W-1:2], 2'b00};
        2'd2: if (!busy) dst_d = {s_data_i[ADDR_W-1:2], 2'b00};
        2'd3: if (!busy) len_d = s_data_i[LEN_W-1:0];
        default: ;
      endcase
    end

    // Completion is evaluated after the software clear so that a set wins.
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            cnt_d     = len_q;
            state_d   = StRd;
          end
        end
      end
      StRd: begin
        if (m_gnt_i) begin
          buf_d     = m_data_i;
          cur_src_d = cur_src_q + ADDR_W'(4);
          state_d   = StWr;
        end
      end
      StWr: begin
        if (m_gnt_i) begin
          cur_dst_d = cur_dst_q + ADDR_W'(4);
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      ien_q     <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      ien_q     <= ien_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
    end
  end

  // Master outputs decode only registered state, so they hold steady while ungranted.
  always_comb begin
    m_req_o  = 1'b0;
    m_we_o   = 1'b0;
    m_addr_o = '0;
    m_data_o = '0;
    unique case (state_q)
      StRd: begin
        m_req_o  = 1'b1;
        m_addr_o = cur_src_q;
      end
      StWr: begin
        m_req_o  = 1'b1;
        m_we_o   = 1'b1;
        m_addr_o = cur_dst_q;
        m_data_o = buf_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_data_o = '0;
    unique case (reg_sel)
      2'd0:    s_data_o = DATA_W'({ien_q, done_q, busy, 1'b0});
      2'd1:    s_data_o = DATA_W'(src_q);
      2'd2:    s_data_o = DATA_W'(dst_q);
      2'd3:    s_data_o = DATA_W'(len_q);
      default: s_data_o = '0;
    endcase
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_dma_copy.sv
// Scoreboard bench for dma_copy: a bus model serves reads from an address-derived pattern
// and checks every granted master access against expectations queued when a copy is started.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_addr_i = '0;
  logic [31:0] s_data_i = '0;
  logic [31:0] s_data_o;
  logic        s_we_i = 1'b0;
  logic [31:0] m_addr_o;
  logic [31:0] m_data_o;
  logic [31:0] m_data_i = '0;
  logic        m_req_o;
  logic        m_we_o;
  logic        m_gnt_i = 1'b0;
  logic        irq_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd_q[$];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];

  int          stall_n = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  int          rd_gnt = 0;
  logic        req_prev = 1'b0, gnt_prev = 1'b0, we_prev = 1'b0;
  logic [31:0] addr_prev = '0, data_prev = '0;

  dma_copy dut (
    .clk      (clk),
    .rst      (rst),
    .s_addr_i (s_addr_i),
    .s_data_i (s_data_i),
    .s_data_o (s_data_o),
    .s_we_i   (s_we_i),
    .m_addr_o (m_addr_o),
    .m_data_o (m_data_o),
    .m_data_i (m_data_i),
    .m_req_o  (m_req_o),
    .m_we_o   (m_we_o),
    .m_gnt_i  (m_gnt_i),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus slave model: decides the grant for the current cycle at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      wcnt    = 0;
      m_gnt_i = 1'b0;
    end else if (m_req_o) begin
      req_cycles++;
      if (req_prev && !gnt_prev) begin
        check_eq("hold_addr", m_addr_o, addr_prev);
        check_eq("hold_we", 32'(m_we_o), 32'(we_prev));
        check_eq("hold_data", m_data_o, data_prev);
      end
      m_gnt_i  = (wcnt >= stall_n);
      m_data_i = m_we_o ? 32'h0 : pat(m_addr_o);
      if (m_gnt_i) begin
        wcnt = 0;
        if (!m_we_o) begin
          rd_gnt++;
          if (rd_q.size() == 0) check_eq("rd_extra", m_addr_o, 32'hDEAD_BEEF);
          else check_eq("rd_addr", m_addr_o, rd_q.pop_front());
        end else begin
          if (wr_a_q.size() == 0) begin
            check_eq("wr_extra", m_addr_o, 32'hDEAD_BEEF);
          end else begin
            check_eq("wr_addr", m_addr_o, wr_a_q.pop_front());
            check_eq("wr_data", m_data_o, wr_d_q.pop_front());
          end
        end
      end else begin
        wcnt++;
      end
    end else begin
      m_gnt_i = 1'b0;
      wcnt    = 0;
    end
    req_prev  = m_req_o;
    gnt_prev  = m_gnt_i;
    we_prev   = m_we_o;
    addr_prev = m_addr_o;
    data_prev = m_data_o;
  end

  task automatic reg_wr(input logic [3:0] off, input logic [31:0] d);
    @(negedge clk);
    s_addr_i = {28'h0, off};
    s_data_i = d;
    s_we_i   = 1'b1;
    @(posedge clk);
    #1 s_we_i = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [31:0] d);
    @(negedge clk);
    s_addr_i = {28'h0, off};
    #1 d = s_data_o;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input logic ien);
    logic [31:0] s, dd;
    reg_wr(4'h4, src);
    reg_wr(4'h8, dst);
    reg_wr(4'hC, len);
    s  = {src[31:2], 2'b00};
    dd = {dst[31:2], 2'b00};
    for (int i = 0; i < int'(len); i++) begin
      rd_q.push_back(s);
      wr_a_q.push_back(dd);
      wr_d_q.push_back(pat(s));
      s  = s + 32'd4;
      dd = dd + 32'd4;
    end
    reg_wr(4'h0, {28'h0, ien, 3'b101});
  endtask

  task automatic wait_done(input int budget, output int cyc, output logic first_busy);
    logic [31:0] v;
    cyc = 0;
    v   = '0;
    first_busy = 1'b0;
    while (!v[2] && cyc < budget) begin
      reg_rd(4'h0, v);
      if (cyc == 0) first_busy = v[1];
      cyc++;
    end
    check_eq("done_seen", 32'(v[2]), 32'd1);
    check_eq("busy_after", 32'(v[1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          cyc;
    logic        fb;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(m_req_o), 32'd0);
    check_eq("rst_we", 32'(m_we_o), 32'd0);
    check_eq("rst_addr", m_addr_o, 32'd0);
    check_eq("rst_data", m_data_o, 32'd0);
    check_eq("rst_irq", 32'(irq_o), 32'd0);
    rst = 1'b0;
    reg_rd(4'h0, v);
    check_eq("rst_ctrl", v, 32'd0);
    reg_rd(4'h4, v);
    check_eq("rst_src", v, 32'd0);

    // Basic copy with continuous grant
    stall_n = 0; req_cycles = 0;
    start_copy(32'h1000_0000, 32'h1000_0100, 32'd3, 1'b0);
    wait_done(50, cyc, fb);
    check_eq("basic_busy", 32'(fb), 32'd1);
    check_eq("basic_cycles", 32'(cyc), 32'd7);
    check_eq("basic_req", 32'(req_cycles), 32'd6);
    check_eq("basic_rdq", 32'(rd_q.size()), 32'd0);
    check_eq("basic_wrq", 32'(wr_a_q.size()), 32'd0);

    // Stalled grant: five ungranted cycles per access
    stall_n = 5; req_cycles = 0;
    start_copy(32'h2000_0000, 32'h3000_0040, 32'd2, 1'b0);
    wait_done(100, cyc, fb);
    check_eq("stall_req", 32'(req_cycles), 32'd24);
    check_eq("stall_wrq", 32'(wr_a_q.size()), 32'd0);

    // Zero length with interrupt
    stall_n = 0; req_cycles = 0;
    start_copy(32'h7000_0000, 32'h7000_1000, 32'd0, 1'b1);
    wait_done(10, cyc, fb);
    check_eq("zero_cycles", 32'(cyc), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("zero_irq", 32'(irq_o), 32'd1);
    check_eq("zero_req", 32'(req_cycles), 32'd0);
    reg_wr(4'h0, 32'h4);
    repeat (2) @(negedge clk);
    check_eq("clr_irq", 32'(irq_o), 32'd0);
    reg_rd(4'h0, v);
    check_eq("clr_ctrl", v, 32'd0);

    // Busy protection and address wrap
    stall_n = 2;
    start_copy(32'hFFFF_FFFC, 32'h4000_0000, 32'd2, 1'b0);
    reg_wr(4'h4, 32'h0);
    reg_wr(4'hC, 32'd9);
    wait_done(100, cyc, fb);
    reg_rd(4'h4, v);
    check_eq("busy_src", v, 32'hFFFF_FFFC);
    reg_rd(4'hC, v);
    check_eq("busy_len", v, 32'd2);
    check_eq("wrap_rdq", 32'(rd_q.size()), 32'd0);

    // Unaligned program, then reset abort mid-transfer
    stall_n = 0;
    reg_wr(4'h4, 32'h1000_0003);
    reg_rd(4'h4, v);
    check_eq("unal_src", v, 32'h1000_0000);
    reg_wr(4'h0, 32'h8);
    rd_gnt = 0;
    start_copy(32'h1000_0003, 32'h5000_0000, 32'd3, 1'b1);
    cyc = 0;
    while (rd_gnt < 2 && cyc < 50) begin
      @(negedge clk);
      #1 cyc++;
    end
    check_eq("abort_reach", 32'(rd_gnt), 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_req", 32'(m_req_o), 32'd0);
    check_eq("abort_we", 32'(m_we_o), 32'd0);
    check_eq("abort_addr", m_addr_o, 32'd0);
    check_eq("abort_data", m_data_o, 32'd0);
    check_eq("abort_irq", 32'(irq_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_q.delete();
    wr_a_q.delete();
    wr_d_q.delete();
    reg_rd(4'h0, v);
    check_eq("abort_ctrl", v, 32'd0);
    req_cycles = 0;
    start_copy(32'h6000_0000, 32'h6000_1000, 32'd2, 1'b0);
    wait_done(50, cyc, fb);
    check_eq("post_cycles", 32'(cyc), 32'd5);
    check_eq("post_req", 32'(req_cycles), 32'd4);
    check_eq("post_wrq", 32'(wr_a_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
